odd_stream_checker: RTL and testbench

Downstream consumer of the 8-bit odd-counter stream: samples each valid count word, confirms it is the odd sequence 1, 3, 5, … advancing by a fixed step, and reports lock status, per-sample mismatches, a saturating error count and sequence wrap events. It sits directly after the odd counter in the counter/test-pattern path and serves as its self-check and monitor stage.

---
 rtl/odd_stream_checker.sv | 171 +++++++++++++++++
 tb/tb_odd_stream_checker.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_stream_checker.sv
// odd_stream_checker
//   Monitors the odd-counter stream. Each valid sample is checked against the
//   expected next value (previous + STEP). The checker hunts for an odd value,
//   confirms LOCK_CNT consecutive in-sequence samples, then tracks the stream
//   and flags mismatches. After LOSS_CNT consecutive mismatches it drops lock.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   valid_i    : data_i carries a sample this cycle
//   data_i     : count value under test
//   clear_i    : synchronous clear of error count, forces HUNT
//   locked_o   : high while locked onto the sequence
//   err_o      : one-cycle pulse, mismatch while locked
//   wrap_o     : one-cycle pulse, matched sample whose data + STEP overflows
//   err_cnt_o  : saturating mismatch count
//   expected_o : next expected value
module odd_stream_checker #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = 2,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic             wrap_o,
    output logic [7:0]       err_cnt_o,
    output logic [WIDTH-1:0] expected_o
);

    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BadW  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StConfirm = 2'd1,
        StLocked  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [GoodW-1:0]   good_q, good_d;
    logic [BadW-1:0]    bad_q, bad_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               err_q, err_d;
    logic               wrap_q, wrap_d;

    // data + STEP with the carry bit kept for wrap detection
    logic [WIDTH:0]     data_sum;
    logic               match;
    logic [GoodW-1:0]   good_inc;
    logic [BadW-1:0]    bad_inc;

    assign data_sum = {1'b0, data_i} + (WIDTH + 1)'(STEP);
    assign match    = (data_i == exp_q);
    assign good_inc = good_q + 1'b1;
    assign bad_inc  = bad_q + 1'b1;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StHunt;
            good_q    <= '0;
            bad_q     <= '0;
            exp_q     <= WIDTH'(1);
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            exp_q     <= exp_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        exp_d     = exp_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        wrap_d    = 1'b0;

        if (clear_i) begin
            // Clear wins over a coincident sample; exp is deliberately kept.
            state_d   = StHunt;
            good_d    = '0;
            bad_d     = '0;
            err_cnt_d = '0;
        end else if (valid_i) begin
            unique case (state_q)
                StHunt: begin
                    if (data_i[0]) begin
                        exp_d = data_sum[WIDTH-1:0];
                        if (LOCK_CNT == 1) begin
                            state_d = StLocked;
                            good_d  = '0;
                        end else begin
                            state_d = StConfirm;
                            good_d  = GoodW'(1);
                        end
                    end
                end
                StConfirm: begin
                    if (match) begin
                        exp_d  = data_sum[WIDTH-1:0];
                        wrap_d = data_sum[WIDTH];
                        if (good_inc == GoodW'(LOCK_CNT)) begin
                            state_d = StLocked;
                            good_d  = '0;
                        end else begin
                            good_d = good_inc;
                        end
                    end else if (data_i[0]) begin
                        // Odd but out of sequence: restart confirmation here
                        good_d = GoodW'(1);
                        exp_d  = data_sum[WIDTH-1:0];
                    end else begin
                        state_d = StHunt;
                        good_d  = '0;
                    end
                end
                StLocked: begin
                    // Flywheel: expectation advances whether or not the sample matched
                    exp_d = exp_q + WIDTH'(STEP);
                    if (match) begin
                        bad_d  = '0;
                        wrap_d = data_sum[WIDTH];
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (bad_inc == BadW'(LOSS_CNT)) begin
                            state_d = StHunt;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        locked_o   = (state_q == StLocked);
        err_o      = err_q;
        wrap_o     = wrap_q;
        err_cnt_o  = err_cnt_q;
        expected_o = exp_q;
    end

endmodule

// File: tb/tb_odd_stream_checker.sv
module tb_odd_stream_checker;

    localparam int unsigned STEP     = 2;
    localparam int unsigned LOCK_CNT = 3;
    localparam int unsigned LOSS_CNT = 2;

    logic       clk;
    logic       reset;
    logic       valid_i;
    logic [7:0] data_i;
    logic       clear_i;
    logic       locked_o;
    logic       err_o;
    logic       wrap_o;
    logic [7:0] err_cnt_o;
    logic [7:0] expected_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_locked;
    bit m_err;
    bit m_wrap;
    int m_run;   // consecutive good samples while acquiring; 0 means hunting
    int m_bad;
    int m_exp;
    int m_cnt;

    odd_stream_checker #(
        .WIDTH    (8),
        .STEP     (STEP),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .clear_i    (clear_i),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .wrap_o     (wrap_o),
        .err_cnt_o  (err_cnt_o),
        .expected_o (expected_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] obs();
        return {locked_o, err_o, wrap_o, err_cnt_o, expected_o};
    endfunction

    function automatic logic [18:0] model_vec();
        logic [7:0] c;
        logic [7:0] e;
        c = m_cnt[7:0];
        e = m_exp[7:0];
        return {m_locked, m_err, m_wrap, c, e};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_wrap = 0;
        m_run = 0; m_bad = 0; m_exp = 1; m_cnt = 0;
    endtask

    task automatic model_step(input bit c, input bit v, input int d);
        int  nxt;
        bit  carry;
        m_err  = 0;
        m_wrap = 0;
        if (c) begin
            m_cnt = 0; m_locked = 0; m_run = 0; m_bad = 0;
        end else if (v) begin
            nxt   = (d + STEP) % 256;
            carry = (d + STEP) > 255;
            if (m_locked) begin
                if (d == m_exp) begin
                    m_bad  = 0;
                    m_wrap = carry;
                end else begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin
                        m_locked = 0; m_bad = 0; m_run = 0;
                    end
                end
                m_exp = (m_exp + STEP) % 256;
            end else if (m_run > 0) begin
                if (d == m_exp) begin
                    m_run++;
                    m_exp  = nxt;
                    m_wrap = carry;
                    if (m_run == LOCK_CNT) begin
                        m_locked = 1; m_run = 0;
                    end
                end else if (d % 2 == 1) begin
                    m_run = 1; m_exp = nxt;
                end else begin
                    m_run = 0;
                end
            end else if (d % 2 == 1) begin
                m_exp = nxt;
                m_run = 1;
                if (LOCK_CNT == 1) begin
                    m_locked = 1; m_run = 0;
                end
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge
    task automatic drive(input bit c, input bit v, input int d);
        @(negedge clk);
        clear_i = c;
        valid_i = v;
        data_i  = d[7:0];
        @(posedge clk);
        model_step(c, v, d);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; valid_i = 1'b0; clear_i = 1'b0; data_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 19'h00001) begin
            errors++;
            $display("FAIL reset_values got %h want %h", obs(), 19'h00001);
        end
        reset = 1'b1;
        drive(0, 0, 0);
        checks++;
        if (obs() !== model_vec()) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs(), model_vec());
        end
    endtask

    task automatic test_lock();
        int seq[4] = '{1, 3, 5, 7};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, seq[i]);
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL lock_seq[%0d] got %h want %h", i, obs(), model_vec());
            end
            if (i >= 2) begin
                checks++;
                if (locked_o !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_locked[%0d] got %b want 1", i, locked_o);
                end
            end
        end
        checks++;
        if (expected_o !== 8'd9) begin
            errors++;
            $display("FAIL lock_expected got %0d want 9", expected_o);
        end
    endtask

    task automatic test_flywheel();
        int seq[4] = '{9, 11, 20, 15};
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, seq[i]);
            if (err_o === 1'b1) pulses++;
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL flywheel_seq[%0d] got %h want %h", i, obs(), model_vec());
            end
        end
        checks++;
        if (pulses != 1 || err_cnt_o !== 8'd1 || locked_o !== 1'b1 || expected_o !== 8'd17) begin
            errors++;
            $display("FAIL flywheel_summary got pulses=%0d cnt=%0d lock=%b exp=%0d want 1 1 1 17",
                     pulses, err_cnt_o, locked_o, expected_o);
        end
    endtask

    task automatic test_loss_relock();
        int seq[5] = '{40, 42, 17, 19, 21};
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, seq[i]);
            if (err_o === 1'b1) pulses++;
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL loss_seq[%0d] got %h want %h", i, obs(), model_vec());
            end
            if (i == 1) begin
                checks++;
                if (locked_o !== 1'b0 || pulses != 2 || err_cnt_o !== 8'd3) begin
                    errors++;
                    $display("FAIL loss_drop got lock=%b pulses=%0d cnt=%0d want 0 2 3",
                             locked_o, pulses, err_cnt_o);
                end
            end
        end
        checks++;
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL loss_relock got %b want 1", locked_o);
        end
    endtask

    task automatic test_wrap();
        int seq[9] = '{0, 245, 247, 249, 251, 253, 255, 1, 3};
        int wraps = 0;
        for (int i = 0; i < 9; i++) begin
            drive(i == 0, i != 0, seq[i]);
            if (wrap_o === 1'b1) wraps++;
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL wrap_seq[%0d] got %h want %h", i, obs(), model_vec());
            end
            if (i == 6) begin
                checks++;
                if (wrap_o !== 1'b1 || err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_pulse got wrap=%b err=%b want 1 0", wrap_o, err_o);
                end
            end
            if (i == 7) begin
                checks++;
                if (expected_o !== 8'd3) begin
                    errors++;
                    $display("FAIL wrap_expected got %0d want 3", expected_o);
                end
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL wrap_count got %0d want 1", wraps);
        end
    endtask

    task automatic test_hunt();
        int seq[9] = '{0, 4, 6, 3, 5, 8, 1, 3, 5};
        int pulses = 0;
        for (int i = 0; i < 9; i++) begin
            drive(i == 0, i != 0, seq[i]);
            if (err_o === 1'b1) pulses++;
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL hunt_seq[%0d] got %h want %h", i, obs(), model_vec());
            end
            if (i == 5) begin
                checks++;
                if (locked_o !== 1'b0 || expected_o !== 8'd7) begin
                    errors++;
                    $display("FAIL hunt_even got lock=%b exp=%0d want 0 7", locked_o, expected_o);
                end
            end
        end
        checks++;
        if (pulses != 0 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL hunt_final got pulses=%0d lock=%b want 0 1", pulses, locked_o);
        end
    endtask

    task automatic test_saturation();
        int bad;
        for (int i = 0; i < 262; i++) begin
            bad = m_exp ^ ($urandom_range(1, 255) & 8'hFE);
            drive(0, 1, bad);
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL sat_bad[%0d] got %h want %h", i, obs(), model_vec());
            end
            drive(0, 1, m_exp);
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL sat_good[%0d] got %h want %h", i, obs(), model_vec());
            end
        end
        checks++;
        if (err_cnt_o !== 8'd255 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got cnt=%0d lock=%b want 255 1", err_cnt_o, locked_o);
        end
    endtask

    task automatic test_clear_with_valid();
        int saved;
        saved = m_exp;
        drive(1, 1, m_exp);
        checks++;
        if (err_cnt_o !== 8'd0 || locked_o !== 1'b0 || int'(expected_o) != saved) begin
            errors++;
            $display("FAIL clear_valid got cnt=%0d lock=%b exp=%0d want 0 0 %0d",
                     err_cnt_o, locked_o, expected_o, saved);
        end
        drive(0, 0, 0);
        checks++;
        if (obs() !== model_vec()) begin
            errors++;
            $display("FAIL clear_idle got %h want %h", obs(), model_vec());
        end
    endtask

    task automatic test_random();
        int r;
        int d;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) < 8) d = m_exp;
            else d = $urandom_range(0, 255);
            drive(r < 2, r >= 15, d);
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d] got %h want %h", i, obs(), model_vec());
            end
        end
    endtask

    task automatic test_reset_midlock();
        int seq[3] = '{101, 103, 105};
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, seq[i]);
        drive(0, 1, 99);
        checks++;
        if (locked_o !== 1'b1 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL midlock_pre got lock=%b err=%b want 1 1", locked_o, err_o);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== 19'h00001) begin
            errors++;
            $display("FAIL midlock_async got %h want %h", obs(), 19'h00001);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 2 * i + 1);
            checks++;
            if (obs() !== model_vec()) begin
                errors++;
                $display("FAIL midlock_reacq[%0d] got %h want %h", i, obs(), model_vec());
            end
        end
        checks++;
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL midlock_relock got %b want 1", locked_o);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_flywheel();
        test_loss_relock();
        test_wrap();
        test_hunt();
        test_saturation();
        test_clear_with_valid();
        test_random();
        test_reset_midlock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
